mem_stage_mc: RTL and testbench

// - Parametrised MEM pipeline stage: EX/MEM register, byte-addressable data RAM with sub-word access,

---
 rtl/mem_pkg.sv | 46 ++++
 rtl/mem_stage_mc_load_align.sv | 28 ++
 rtl/mem_stage_mc.sv | 170 +++++++++++++++++
 tb/tb_mem_stage_mc.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and helpers for the MEM pipeline stage: access sizes, latency
// FSM states, PC redirect encodings and store lane helpers.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  localparam logic [1:0] PC_SRC_SEQ = 2'b00;
  localparam logic [1:0] PC_SRC_BR  = 2'b01;
  localparam logic [1:0] PC_SRC_J   = 2'b10;

  // Byte enables for a store of the given size starting at the given lane
  function automatic logic [3:0] byte_enables(input size_e size, input logic [1:0] lane);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SZ_B:    be = 4'b0001 << lane;
      SZ_H:    be = 4'b0011 << lane;
      SZ_W:    be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Right-aligned store data copied into every lane it could land in
  function automatic logic [31:0] replicate_store(input size_e size, input logic [31:0] data);
    logic [31:0] rep;
    rep = data;
    case (size)
      SZ_B:    rep = {4{data[7:0]}};
      SZ_H:    rep = {2{data[15:0]}};
      default: rep = data;
    endcase
    return rep;
  endfunction

endpackage

// File: rtl/mem_stage_mc_load_align.sv
// Load alignment: picks the addressed byte/halfword out of a RAM word and
// sign- or zero-extends it to 32 bits.
module load_align
  import mem_pkg::*;
(
  input  logic  [31:0] rdata,
  input  logic  [1:0]  lane,
  input  size_e        size,
  input  logic         is_unsigned,
  output logic  [31:0] result
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Lane select followed by extension according to size and signedness
  always_comb begin
    byte_val = rdata[{lane, 3'b000} +: 8];
    half_val = lane[1] ? rdata[31:16] : rdata[15:0];
    result   = rdata;
    case (size)
      SZ_B:    result = {{24{~is_unsigned & byte_val[7]}}, byte_val};
      SZ_H:    result = {{16{~is_unsigned & half_val[15]}}, half_val};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_mc.sv
// MEM pipeline stage: EX/MEM register, byte-addressable data RAM with
// sub-word access, optional multi-cycle access latency with stall, alignment
// and range checking, and branch/jump redirect towards IF.
module mem_stage_mc
  import mem_pkg::*;
#(
  parameter int DEPTH     = 1024,
  parameter int MEM_LAT   = 0,
  parameter     INIT_FILE = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_write_e,
  input  logic        mem_to_reg_e,
  input  logic        mem_read_e,
  input  logic        mem_write_e,
  input  logic [1:0]  mem_size_e,
  input  logic        mem_unsigned_e,
  input  logic        branch_e,
  input  logic        zero_e,
  input  logic        j_inst_e,
  input  logic [31:0] alu_out_e,
  input  logic [31:0] write_data_e,
  input  logic [4:0]  write_reg_e,
  input  logic [31:0] pc_branch_e,
  input  logic [31:0] jump_addr_e,
  output logic        stall,
  output logic        err_m,
  output logic [31:0] read_data_m,
  output logic [31:0] alu_out_m,
  output logic [4:0]  write_reg_m,
  output logic        reg_write_m,
  output logic        mem_to_reg_m,
  output logic [1:0]  if_pc_src,
  output logic [31:0] if_pc_branch_in
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;

  logic        mem_read_m;
  logic        mem_write_m;
  size_e       size_m;
  logic        unsigned_m;
  logic [31:0] write_data_m;

  logic [AW-1:0] idx;
  logic [1:0]    lane;
  logic          access_m;
  logic          misaligned;
  logic          out_of_range;
  logic          valid_access;
  logic          mem_done;
  logic          we;
  logic [3:0]    be;
  logic [31:0]   wdata_rep;
  logic [31:0]   load_val;

  mem_state_e       state;
  logic [CNT_W-1:0] cnt;

  logic [3:0][7:0] ram [DEPTH];

  // EX/MEM register: capture the EX controls and data unless MEM is busy
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_m  <= 1'b0;
      mem_to_reg_m <= 1'b0;
      mem_read_m   <= 1'b0;
      mem_write_m  <= 1'b0;
      size_m       <= SZ_B;
      unsigned_m   <= 1'b0;
      alu_out_m    <= '0;
      write_data_m <= '0;
      write_reg_m  <= '0;
    end else if (!stall) begin
      reg_write_m  <= reg_write_e;
      mem_to_reg_m <= mem_to_reg_e;
      mem_read_m   <= mem_read_e;
      mem_write_m  <= mem_write_e;
      size_m       <= size_e'(mem_size_e);
      unsigned_m   <= mem_unsigned_e;
      alu_out_m    <= alu_out_e;
      write_data_m <= write_data_e;
      write_reg_m  <= write_reg_e;
    end
  end

  // Address decode, alignment/range checking and access qualification
  always_comb begin
    idx          = alu_out_m[AW+1:2];
    lane         = alu_out_m[1:0];
    access_m     = mem_read_m | mem_write_m;
    misaligned   = ((size_m == SZ_H) && lane[0]) || ((size_m == SZ_W) && (lane != 2'b00));
    out_of_range = |alu_out_m[31:AW+2];
    err_m        = access_m && (misaligned || out_of_range);
    valid_access = access_m && !err_m;
    mem_done     = (MEM_LAT == 0) || (state == DONE);
    stall        = (MEM_LAT > 0) && valid_access && (state != DONE);
    we           = valid_access && mem_write_m && mem_done && !rst;
    be           = byte_enables(size_m, lane);
    wdata_rep    = replicate_store(size_m, write_data_m);
  end

  // Latency FSM: one IDLE stall cycle, WAIT until the count is reached, then DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if ((MEM_LAT > 0) && valid_access) begin
            cnt   <= CNT_W'(1);
            state <= (MEM_LAT == 1) ? DONE : WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(MEM_LAT - 1)) begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // RAM write port: only the enabled byte lanes are updated
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          ram[idx][b] <= wdata_rep[b*8 +: 8];
        end
      end
    end
  end

  load_align u_load_align (
    .rdata       (ram[idx]),
    .lane        (lane),
    .size        (size_m),
    .is_unsigned (unsigned_m),
    .result      (load_val)
  );

  // Load result is only presented for a valid load once the access completes
  always_comb begin
    read_data_m = '0;
    if (valid_access && mem_read_m && mem_done) begin
      read_data_m = load_val;
    end
  end

  // Redirect straight from EX; a taken branch has priority over a jump
  always_comb begin
    if_pc_src       = PC_SRC_SEQ;
    if_pc_branch_in = '0;
    if (branch_e && zero_e) begin
      if_pc_src       = PC_SRC_BR;
      if_pc_branch_in = pc_branch_e;
    end else if (j_inst_e) begin
      if_pc_src       = PC_SRC_J;
      if_pc_branch_in = jump_addr_e;
    end
  end

endmodule

// File: tb/tb_mem_stage_mc.sv
// Testbench for mem_stage_mc: a zero-latency instance and a three-cycle
// instance, driven with directed memory operations. Expected results go into
// per-instance queues and monitors compare them as each op leaves MEM.
module tb_mem_stage_mc;
  import mem_pkg::*;

  typedef struct packed {
    logic        reg_write;
    logic        mem_to_reg;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  size;
    logic        uns;
    logic        branch;
    logic        zero;
    logic        j;
    logic [31:0] alu_out;
    logic [31:0] wdata;
    logic [4:0]  wreg;
    logic [31:0] pcb;
    logic [31:0] ja;
  } ex_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [31:0] addr;
    logic [4:0]  wreg;
    logic        m2r;
    int          stalls;
  } exp_t;

  logic clk = 1'b0;
  logic rst0 = 1'b1;
  logic rst1 = 1'b1;
  ex_t  ex0 = '0;
  ex_t  ex1 = '0;

  logic        d0_stall, d0_err_m, d0_reg_write_m, d0_mem_to_reg_m;
  logic [31:0] d0_read_data_m, d0_alu_out_m, d0_pc_branch_in;
  logic [4:0]  d0_write_reg_m;
  logic [1:0]  d0_pc_src;
  logic        d1_stall, d1_err_m, d1_reg_write_m, d1_mem_to_reg_m;
  logic [31:0] d1_read_data_m, d1_alu_out_m, d1_pc_branch_in;
  logic [4:0]  d1_write_reg_m;
  logic [1:0]  d1_pc_src;

  exp_t q0[$];
  exp_t q1[$];
  int total = 0;
  int bad = 0;
  int run0 = 0;
  int run1 = 0;
  logic [4:0] tag = 5'd0;

  always #5 clk = ~clk;

  mem_stage_mc #(.DEPTH(1024), .MEM_LAT(0)) dut0 (
    .clk(clk), .rst(rst0),
    .reg_write_e(ex0.reg_write), .mem_to_reg_e(ex0.mem_to_reg),
    .mem_read_e(ex0.mem_read), .mem_write_e(ex0.mem_write),
    .mem_size_e(ex0.size), .mem_unsigned_e(ex0.uns),
    .branch_e(ex0.branch), .zero_e(ex0.zero), .j_inst_e(ex0.j),
    .alu_out_e(ex0.alu_out), .write_data_e(ex0.wdata), .write_reg_e(ex0.wreg),
    .pc_branch_e(ex0.pcb), .jump_addr_e(ex0.ja),
    .stall(d0_stall), .err_m(d0_err_m), .read_data_m(d0_read_data_m),
    .alu_out_m(d0_alu_out_m), .write_reg_m(d0_write_reg_m),
    .reg_write_m(d0_reg_write_m), .mem_to_reg_m(d0_mem_to_reg_m),
    .if_pc_src(d0_pc_src), .if_pc_branch_in(d0_pc_branch_in)
  );

  mem_stage_mc #(.DEPTH(1024), .MEM_LAT(3)) dut1 (
    .clk(clk), .rst(rst1),
    .reg_write_e(ex1.reg_write), .mem_to_reg_e(ex1.mem_to_reg),
    .mem_read_e(ex1.mem_read), .mem_write_e(ex1.mem_write),
    .mem_size_e(ex1.size), .mem_unsigned_e(ex1.uns),
    .branch_e(ex1.branch), .zero_e(ex1.zero), .j_inst_e(ex1.j),
    .alu_out_e(ex1.alu_out), .write_data_e(ex1.wdata), .write_reg_e(ex1.wreg),
    .pc_branch_e(ex1.pcb), .jump_addr_e(ex1.ja),
    .stall(d1_stall), .err_m(d1_err_m), .read_data_m(d1_read_data_m),
    .alu_out_m(d1_alu_out_m), .write_reg_m(d1_write_reg_m),
    .reg_write_m(d1_reg_write_m), .mem_to_reg_m(d1_mem_to_reg_m),
    .if_pc_src(d1_pc_src), .if_pc_branch_in(d1_pc_branch_in)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  function automatic ex_t mk(input logic rd, input logic wr, input logic [1:0] sz,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wd);
    ex_t x;
    x = '0;
    x.reg_write  = 1'b1;
    x.mem_to_reg = rd;
    x.mem_read   = rd;
    x.mem_write  = wr;
    x.size       = sz;
    x.uns        = uns;
    x.alu_out    = addr;
    x.wdata      = wd;
    return x;
  endfunction

  // Drive one op into EX (called at posedge+1), queue its expected result,
  // hold it until the stage accepts it, then leave a bubble behind.
  task automatic applyStimulus(input int which, input ex_t ex, input logic [31:0] rdata,
                               input logic err, input int stalls, input bit track);
    ex_t  x;
    exp_t e;
    int   n;
    x = ex;
    tag = (tag == 5'd31) ? 5'd1 : tag + 5'd1;
    x.wreg = tag;
    e.rdata = rdata; e.err = err; e.addr = x.alu_out;
    e.wreg = x.wreg; e.m2r = x.mem_to_reg; e.stalls = stalls;
    if (which == 0) begin
      if (track) q0.push_back(e);
      ex0 = x;
    end else begin
      if (track) q1.push_back(e);
      ex1 = x;
    end
    n = 0;
    @(negedge clk);
    while (((which == 0) ? d0_stall : d1_stall) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) checkOutput("capture timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    if (which == 0) ex0 = '0;
    else ex1 = '0;
  endtask

  // Monitor for the zero-latency instance
  always @(negedge clk) begin : mon0
    exp_t e;
    if (rst0) run0 = 0;
    else if (d0_stall) run0++;
    else begin
      if (d0_reg_write_m) begin
        if (q0.size() == 0) checkOutput("d0 unexpected op", 32'd1, 32'd0);
        else begin
          e = q0.pop_front();
          checkOutput("d0 read_data_m", d0_read_data_m, e.rdata);
          checkOutput("d0 err_m", 32'(d0_err_m), 32'(e.err));
          checkOutput("d0 alu_out_m", d0_alu_out_m, e.addr);
          checkOutput("d0 write_reg_m", 32'(d0_write_reg_m), 32'(e.wreg));
          checkOutput("d0 mem_to_reg_m", 32'(d0_mem_to_reg_m), 32'(e.m2r));
          checkOutput("d0 stall cycles", 32'(run0), 32'(e.stalls));
        end
      end
      run0 = 0;
    end
  end

  // Monitor for the three-cycle instance
  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst1) run1 = 0;
    else if (d1_stall) run1++;
    else begin
      if (d1_reg_write_m) begin
        if (q1.size() == 0) checkOutput("d1 unexpected op", 32'd1, 32'd0);
        else begin
          e = q1.pop_front();
          checkOutput("d1 read_data_m", d1_read_data_m, e.rdata);
          checkOutput("d1 err_m", 32'(d1_err_m), 32'(e.err));
          checkOutput("d1 alu_out_m", d1_alu_out_m, e.addr);
          checkOutput("d1 write_reg_m", 32'(d1_write_reg_m), 32'(e.wreg));
          checkOutput("d1 mem_to_reg_m", 32'(d1_mem_to_reg_m), 32'(e.m2r));
          checkOutput("d1 stall cycles", 32'(run1), 32'(e.stalls));
        end
      end
      run1 = 0;
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin : stim
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset d0 stall", 32'(d0_stall), 32'd0);
    checkOutput("reset d0 err_m", 32'(d0_err_m), 32'd0);
    checkOutput("reset d0 read_data_m", d0_read_data_m, 32'd0);
    checkOutput("reset d0 alu_out_m", d0_alu_out_m, 32'd0);
    checkOutput("reset d0 reg_write_m", 32'(d0_reg_write_m), 32'd0);
    checkOutput("reset d1 stall", 32'(d1_stall), 32'd0);
    checkOutput("reset d1 write_reg_m", 32'(d1_write_reg_m), 32'd0);
    checkOutput("reset d1 mem_to_reg_m", 32'(d1_mem_to_reg_m), 32'd0);
    checkOutput("reset pc_src", 32'(d0_pc_src), 32'd0);
    @(posedge clk);
    #1;
    rst0 = 1'b0;
    rst1 = 1'b0;

    // Zero-latency instance: word store then sub-word loads
    applyStimulus(0, mk(0, 1, SZ_W, 0, 32'h10, 32'hDEADBEEF), 32'h0, 0, 0, 1);
    applyStimulus(0, mk(1, 0, SZ_B, 0, 32'h13, 32'h0), 32'hFFFFFFDE, 0, 0, 1);
    applyStimulus(0, mk(1, 0, SZ_B, 1, 32'h13, 32'h0), 32'h000000DE, 0, 0, 1);
    applyStimulus(0, mk(1, 0, SZ_H, 0, 32'h10, 32'h0), 32'hFFFFBEEF, 0, 0, 1);
    applyStimulus(0, mk(1, 0, SZ_B, 0, 32'h12, 32'h0), 32'hFFFFFFAD, 0, 0, 1);
    applyStimulus(0, mk(1, 0, SZ_H, 1, 32'h12, 32'h0), 32'h0000DEAD, 0, 0, 1);
    // Byte and halfword stores merging into an existing word
    applyStimulus(0, mk(0, 1, SZ_W, 0, 32'h20, 32'h11223344), 32'h0, 0, 0, 1);
    applyStimulus(0, mk(0, 1, SZ_B, 0, 32'h21, 32'hFFFFFF5A), 32'h0, 0, 0, 1);
    applyStimulus(0, mk(1, 0, SZ_W, 0, 32'h20, 32'h0), 32'h11225A44, 0, 0, 1);
    applyStimulus(0, mk(1, 0, SZ_H, 0, 32'h22, 32'h0), 32'h00001122, 0, 0, 1);
    applyStimulus(0, mk(1, 0, SZ_B, 0, 32'h20, 32'h0), 32'h00000044, 0, 0, 1);
    applyStimulus(0, mk(0, 1, SZ_H, 0, 32'h22, 32'hABCD7777), 32'h0, 0, 0, 1);
    applyStimulus(0, mk(1, 0, SZ_W, 0, 32'h20, 32'h0), 32'h77775A44, 0, 0, 1);
    // Misaligned and out-of-range accesses are flagged and suppressed
    applyStimulus(0, mk(1, 0, SZ_H, 0, 32'h11, 32'h0), 32'h0, 1, 0, 1);
    applyStimulus(0, mk(1, 0, SZ_W, 0, 32'h12, 32'h0), 32'h0, 1, 0, 1);
    applyStimulus(0, mk(0, 1, SZ_W, 0, 32'h12, 32'hCAFEF00D), 32'h0, 1, 0, 1);
    applyStimulus(0, mk(0, 1, SZ_W, 0, 32'h1010, 32'h00000000), 32'h0, 1, 0, 1);
    applyStimulus(0, mk(1, 0, SZ_W, 0, 32'h1000, 32'h0), 32'h0, 1, 0, 1);
    applyStimulus(0, mk(1, 0, SZ_W, 0, 32'h10, 32'h0), 32'hDEADBEEF, 0, 0, 1);

    // Redirect priority and targets
    ex0 = '0;
    ex0.branch = 1'b1; ex0.zero = 1'b1; ex0.j = 1'b1;
    ex0.pcb = 32'h40; ex0.ja = 32'h80;
    #1;
    checkOutput("redirect br+j src", 32'(d0_pc_src), 32'(PC_SRC_BR));
    checkOutput("redirect br+j target", d0_pc_branch_in, 32'h40);
    ex0.branch = 1'b0;
    #1;
    checkOutput("redirect j src", 32'(d0_pc_src), 32'(PC_SRC_J));
    checkOutput("redirect j target", d0_pc_branch_in, 32'h80);
    ex0.branch = 1'b1; ex0.zero = 1'b0; ex0.j = 1'b0;
    #1;
    checkOutput("redirect untaken src", 32'(d0_pc_src), 32'(PC_SRC_SEQ));
    checkOutput("redirect untaken target", d0_pc_branch_in, 32'h0);
    ex0 = '0;
    @(posedge clk);
    #1;

    // Three-cycle instance: every valid access stalls exactly three cycles
    applyStimulus(1, mk(0, 1, SZ_W, 0, 32'h40, 32'h12345678), 32'h0, 0, 3, 1);
    applyStimulus(1, mk(1, 0, SZ_W, 0, 32'h40, 32'h0), 32'h12345678, 0, 3, 1);
    applyStimulus(1, mk(1, 0, SZ_W, 0, 32'h40, 32'h0), 32'h12345678, 0, 3, 1);
    applyStimulus(1, mk(1, 0, SZ_B, 0, 32'h43, 32'h0), 32'h00000012, 0, 3, 1);
    applyStimulus(1, mk(1, 0, SZ_H, 0, 32'h41, 32'h0), 32'h0, 1, 0, 1);
    applyStimulus(1, mk(0, 1, SZ_W, 0, 32'h80, 32'hAAAA5555), 32'h0, 0, 3, 1);
    // Store interrupted by reset while waiting must not reach the RAM
    applyStimulus(1, mk(0, 1, SZ_W, 0, 32'h80, 32'h0BADF00D), 32'h0, 0, 3, 0);
    @(posedge clk);
    #1;
    rst1 = 1'b1;
    @(posedge clk);
    #1;
    rst1 = 1'b0;
    @(negedge clk);
    checkOutput("d1 stall after reset", 32'(d1_stall), 32'd0);
    checkOutput("d1 reg_write_m after reset", 32'(d1_reg_write_m), 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(1, mk(1, 0, SZ_W, 0, 32'h80, 32'h0), 32'hAAAA5555, 0, 3, 1);

    repeat (10) @(posedge clk);
    #1;
    checkOutput("d0 queue drained", 32'(q0.size()), 32'd0);
    checkOutput("d1 queue drained", 32'(q1.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
